// File: rtl/large_digit_render.sv
// Seven-segment renderer for three 3-digit decimal counts drawn in the large-number boxes.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros in each box (units always drawn).
module large_digit_render #(
    parameter logic [10:0] BX0   = 11'd11,
    parameter logic [10:0] BX1   = 11'd211,
    parameter logic [10:0] BX2   = 11'd411,
    parameter logic [9:0]  BY    = 10'd294,
    parameter logic [10:0] CW    = 11'd60,
    parameter int          SEG_T = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [9:0]  cnt0,
    input  logic [9:0]  cnt1,
    input  logic [9:0]  cnt2,
    input  logic [10:0] gr_x,
    input  logic [9:0]  gr_y,
    input  logic        in_box0,
    input  logic        in_box1,
    input  logic        in_box2,
    output logic        pix_on,
    output logic        busy
);

    // Glyph geometry inside a 60x80 cell
    localparam logic [10:0] T  = 11'(SEG_T);
    localparam logic [10:0] XL = 11'd10;
    localparam logic [10:0] XR = 11'd49;
    localparam logic [10:0] YA = 11'd4;
    localparam logic [10:0] YG = 11'd36;
    localparam logic [10:0] YD = 11'd68;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, COMMIT} state_t;

    state_t           state;
    logic [1:0]       ch;
    logic [3:0]       iter;
    logic [21:0]      sr;
    logic [2:0][9:0]  shadow;
    logic [2:0][11:0] stage;
    logic [2:0][11:0] disp;

    function automatic logic [9:0] sat999(input logic [9:0] v);
        return (v > 10'd999) ? 10'd999 : v;
    endfunction

    // One double-dabble step: adjust each BCD nibble, then shift left.
    function automatic logic [21:0] dabble(input logic [21:0] s);
        logic [21:0] r;
        r = s;
        for (int i = 0; i < 3; i++) begin
            if (r[10+4*i +: 4] >= 4'd5)
                r[10+4*i +: 4] = r[10+4*i +: 4] + 4'd3;
        end
        return {r[20:0], 1'b0};
    endfunction

    // Segment order {a,b,c,d,e,f,g}
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            ch     <= 2'd0;
            iter   <= 4'd0;
            sr     <= '0;
            shadow <= '0;
            stage  <= '0;
            disp   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        shadow <= {cnt2, cnt1, cnt0};
                        ch     <= 2'd0;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    sr    <= {12'd0, sat999(shadow[ch])};
                    iter  <= 4'd0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    sr   <= dabble(sr);
                    iter <= iter + 4'd1;
                    if (iter == 4'd9)
                        state <= STORE;
                end
                STORE: begin
                    stage[ch] <= sr[21:10];
                    if (ch < 2'd2) begin
                        ch    <= ch + 2'd1;
                        state <= LOAD;
                    end else begin
                        // busy drops as COMMIT is entered so it spans exactly the conversion
                        busy  <= 1'b0;
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    disp  <= stage;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pixel path: align coords with the flags, then S1 (locate cell), S2 (decode)
    logic [10:0] x_d1;
    logic [9:0]  y_d1;

    logic        s1_vld;
    logic [1:0]  s1_box;
    logic [1:0]  s1_idx;
    logic [10:0] s1_cx;
    logic [10:0] s1_ly;

    logic        hit;
    logic [1:0]  bsel;
    logic [10:0] bx;
    logic [10:0] lx;
    logic [10:0] ly;
    logic [1:0]  idx;
    logic [10:0] cx;

    always_comb begin
        hit  = 1'b1;
        bsel = 2'd0;
        bx   = BX0;
        case ({in_box2, in_box1, in_box0})
            3'b001:  begin bsel = 2'd0; bx = BX0; end
            3'b010:  begin bsel = 2'd1; bx = BX1; end
            3'b100:  begin bsel = 2'd2; bx = BX2; end
            default: hit = 1'b0;
        endcase
        lx = x_d1 - bx;
        ly = {1'b0, y_d1} - {1'b0, BY};
        if (lx < CW) begin
            idx = 2'd0;
            cx  = lx;
        end else if (lx < CW + CW) begin
            idx = 2'd1;
            cx  = lx - CW;
        end else begin
            idx = 2'd2;
            cx  = lx - (CW + CW);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_d1   <= '0;
            y_d1   <= '0;
            s1_vld <= 1'b0;
            s1_box <= 2'd0;
            s1_idx <= 2'd0;
            s1_cx  <= '0;
            s1_ly  <= '0;
        end else begin
            x_d1   <= gr_x;
            y_d1   <= gr_y;
            s1_vld <= hit;
            s1_box <= bsel;
            s1_idx <= idx;
            s1_cx  <= cx;
            s1_ly  <= ly;
        end
    end

    logic [11:0] bcd;
    logic [3:0]  digit;
    logic        blank;
    logic [6:0]  region;
    logic        x_full, x_left, x_right, y_up, y_lo;
    logic        lit;

    always_comb begin
        bcd = disp[s1_box];
        case (s1_idx)
            2'd0:    digit = bcd[11:8];
            2'd1:    digit = bcd[7:4];
            default: digit = bcd[3:0];
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        blank = ((s1_idx == 2'd0) && (bcd[11:8] == 4'd0)) ||
                ((s1_idx == 2'd1) && (bcd[11:4] == 8'd0));
`else
        blank = 1'b0;
`endif
        x_full  = (s1_cx >= XL) && (s1_cx <= XR);
        x_left  = (s1_cx >= XL) && (s1_cx < XL + T);
        x_right = (s1_cx > XR - T) && (s1_cx <= XR);
        y_up    = (s1_ly >= YA) && (s1_ly < YG + T);
        y_lo    = (s1_ly >= YG) && (s1_ly < YD + T);
        region = {x_full  && (s1_ly >= YA) && (s1_ly < YA + T),
                  x_right && y_up,
                  x_right && y_lo,
                  x_full  && (s1_ly >= YD) && (s1_ly < YD + T),
                  x_left  && y_lo,
                  x_left  && y_up,
                  x_full  && (s1_ly >= YG) && (s1_ly < YG + T)};
        lit = s1_vld && !blank && |(seg_decode(digit) & region);
    end

    always_ff @(posedge clk) begin
        if (reset)
            pix_on <= 1'b0;
        else
            pix_on <= lit;
    end

endmodule

// File: tb/tb_large_digit_render.sv
// Scoreboarded bench for large_digit_render: probes push expected pix_on, a monitor pops 3 cycles later.
module tb_large_digit_render;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [9:0]  cnt0 = '0, cnt1 = '0, cnt2 = '0;
    logic [10:0] gr_x = '0;
    logic [9:0]  gr_y = '0;
    logic        in_box0 = 1'b0, in_box1 = 1'b0, in_box2 = 1'b0;
    logic        pix_on, busy;

    large_digit_render dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2),
        .gr_x(gr_x), .gr_y(gr_y),
        .in_box0(in_box0), .in_box1(in_box1), .in_box2(in_box2),
        .pix_on(pix_on), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int    tq[$];
    bit    eq[$];
    string nq[$];

    logic [2:0] nxt = '0;
    bit         force_en = 1'b0;
    logic [2:0] force_val = '0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Upstream box-stage model: flag for a coordinate appears one cycle later
    function automatic logic [2:0] flags(input int x, input int y);
        logic [2:0] f;
        f = '0;
        if (y >= 294 && y <= 373) begin
            f[0] = (x >= 11)  && (x <= 190);
            f[1] = (x >= 211) && (x <= 390);
            f[2] = (x >= 411) && (x <= 590);
        end
        return f;
    endfunction

    task automatic tick(input int x, input int y);
        @(negedge clk);
        gr_x = 11'(x);
        gr_y = 10'(y);
        {in_box2, in_box1, in_box0} = nxt;
        nxt = force_en ? force_val : flags(x, y);
        force_en = 1'b0;
    endtask

    task automatic probe(input int x, input int y, input bit exp, input string name);
        tick(x, y);
        tq.push_back(cyc + 3);
        eq.push_back(exp);
        nq.push_back(name);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0);
    endtask

    // Monitor: compares pix_on whenever a probed coordinate reaches the output
    int  m_t;
    bit  m_e;
    string m_n;
    always @(posedge clk) begin
        #1;
        cyc++;
        while (tq.size() > 0 && tq[0] <= cyc) begin
            m_t = tq.pop_front();
            m_e = eq.pop_front();
            m_n = nq.pop_front();
            check(m_n, (m_t == cyc) ? int'(pix_on) : -1, int'(m_e));
        end
    end

    // Pulse frame_start, then run 45 cycles with optional second pulse, reset, count change
    // and a probe straddling the display update.
    task automatic conv(input bit pb, input bit pb_old, input bit pb_new,
                        input int fs2_at, input int rst_at, input int chg_at,
                        output int blen);
        tick(0, 0);
        frame_start = 1'b1;
        blen = 0;
        for (int i = 1; i <= 45; i++) begin
            if (pb && i == 35)
                probe(91, 334, pb_old, "commit_before");
            else if (pb && i == 36)
                probe(91, 334, pb_new, "commit_after");
            else
                tick(0, 0);
            frame_start = (i == fs2_at);
            reset = (i == rst_at);
            if (i == chg_at) cnt0 = 10'd888;
            if (busy) blen++;
            if (i == rst_at + 1) check("rst_mid_busy", int'(busy), 0);
        end
    endtask

    int blen;

    initial begin
        idle(3);
        reset = 1'b0;
        tick(0, 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pix", int'(pix_on), 0);
        probe(31, 300, !LZ, "rst_b0_h0_a");
        probe(31, 340, 1'b0, "rst_b0_h0_gap");
        probe(151, 300, 1'b1, "rst_b0_u0_a");
        idle(4);

        // 123 / 1023 (saturates to 999) / 5
        cnt0 = 10'd123; cnt1 = 10'd1023; cnt2 = 10'd5;
        conv(1'b1, 1'b0, 1'b1, -1, -1, -1, blen);
        check("busy_len_1", blen, 36);
        probe(91, 334, 1'b1, "b0_t2_g");
        probe(31, 300, 1'b0, "b0_h1_a");
        probe(176, 314, 1'b1, "b0_u3_b");
        probe(143, 314, 1'b0, "b0_u3_f");
        probe(376, 344, 1'b1, "b1_u9_c");
        probe(343, 344, 1'b0, "b1_u9_e");
        probe(231, 300, 1'b1, "b1_h9_a");
        probe(431, 300, !LZ, "b2_h0_a");
        probe(491, 300, !LZ, "b2_t0_a");
        probe(551, 300, 1'b1, "b2_u5_a");
        probe(576, 314, 1'b0, "b2_u5_b");
        force_en = 1'b1; force_val = 3'b011;
        probe(91, 334, 1'b0, "dual_flag");
        probe(5, 300, 1'b0, "out_left");
        probe(200, 334, 1'b0, "out_gap");
        probe(300, 400, 1'b0, "out_below");
        idle(4);

        // 456 with a second pulse at +5 and a count change at +3, both ignored
        cnt0 = 10'd456;
        conv(1'b0, 1'b0, 1'b0, 5, -1, 3, blen);
        check("busy_len_2", blen, 36);
        probe(91, 334, 1'b1, "c2_t5_g");
        probe(116, 314, 1'b0, "c2_t5_b");
        probe(31, 300, 1'b0, "c2_h4_a");
        probe(23, 314, 1'b1, "c2_h4_f");
        idle(4);

        // Reset 20 cycles into a conversion of 888
        conv(1'b0, 1'b0, 1'b0, -1, 20, -1, blen);
        reset = 1'b0;
        check("rst_after_busy", int'(busy), 0);
        probe(91, 334, 1'b0, "rst_t0_g");
        probe(91, 300, !LZ, "rst_t0_a");
        probe(151, 300, 1'b1, "rst_u0_a");
        idle(6);
        check("sb_drain", tq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/large_digit_render.md
Name: large_digit_render

Overview:
- Downstream of the large-number box stage. Renders three 3-digit decimal counts as seven-segment glyphs inside the three on-screen boxes.
- Box extents: x 11..190, 211..390, 411..590; y 294..373 for all three.
- Consumes the per-box region flags and the raster coordinates, and drives a registered pixel-on bit to the video mixer.
- Samples the binary counts once per frame and converts them to BCD with a sequential double-dabble engine, so the display never tears mid-frame.

Parameters:
- BX0, 11, left x of box 0
- BX1, 211, left x of box 1
- BX2, 411, left x of box 2
- BY, 294, top y of all boxes
- CW, 11'd60, digit cell width; 3 cells per 180-px box
- SEG_T, 8, segment thickness in pixels

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- cnt0  in  10  binary count for box 0
- cnt1  in  10  binary count for box 1
- cnt2  in  10  binary count for box 2
- gr_x  in  11  raster x, same cycle as fed to box stage
- gr_y  in  10  raster y, same cycle as fed to box stage
- in_box0  in  1  box-0 flag (registered; lags gr_x/gr_y by 1 cycle)
- in_box1  in  1  box-1 flag
- in_box2  in  1  box-2 flag
- pix_on  out  1  glyph pixel lit
- busy  out  1  BCD conversion in progress

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: pix_on=0, busy=0, FSM=IDLE. All nine display BCD digits=0, so the display shows "000" in each box.
- Coordinate alignment: gr_x/gr_y are registered once internally to align with the in_box flags.
- Pixel pipeline, 2 stages after flag arrival:
  - S1 registers box select and local coords: lx = x_d1 - BXk, ly = y_d1 - BY (11-bit subtract).
  - S1 digit index: 0 if lx<60, 1 if lx<120, else 2. cx = lx - 60*idx.
  - S2 looks up the BCD digit, decodes segments and registers pix_on.
  - pix_on asserts 3 clk after the gr_x/gr_y it corresponds to.
  - No flag set, or more than one flag set: pix_on=0.
- Glyph geometry in the 60x80 cell, inclusive ranges:
  - a: x10..49, y4..11
  - g: x10..49, y36..43
  - d: x10..49, y68..75
  - f: x10..17, y4..43
  - b: x42..49, y4..43
  - e: x10..17, y36..75
  - c: x42..49, y36..75
  - Standard 7-seg truth table for digits 0..9.
- Conversion FSM, states IDLE, LOAD, SHIFT, STORE, COMMIT:
  - IDLE: on frame_start, latch cnt0..cnt2 into a shadow, channel=0 -> LOAD. busy=1 from the next cycle.
  - LOAD: value >999 saturates to 999. Load the shift register with bcd=0 -> SHIFT.
  - SHIFT: 10 iterations of add-3-if-≥5 then shift left 1 -> STORE.
  - STORE: write 12-bit BCD into the staging slot for the channel. If channel<2: channel+1 -> LOAD, else -> COMMIT.
  - COMMIT: copy all three staging slots into the display registers in the same cycle. busy=0 -> IDLE.
  - Total 37 cycles from the frame_start pulse to the display update.
- frame_start while busy=1: ignored, no restart. The display keeps its previous values until COMMIT.
- reset mid-conversion: FSM -> IDLE, staging discarded, display returns to 000.
- Count changes after latching: no effect until the next frame_start.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN
- Defined: in each box the hundreds digit is blanked when it is 0. The tens digit is blanked when hundreds and tens are both 0. The units digit is always shown. Example: 7 displays as "  7", 40 as " 40".
- Undefined: all three digits are always drawn. Example: 7 displays as "007".

Test Plan:
- Reset, then raster x=31, y=300 -> in_box0 seen next cycle, pix_on=1 three cycles after coords (segment a of digit "0"). x=31, y=340 -> pix_on=0 (segment g off for "0").
- cnt0=123, frame_start pulse -> busy high for 36 cycles, display updated at cycle 37. x=11+60+20, y=294+40 -> pix_on=1 (segment g of "2").
- cnt1=1023 -> box 1 shows 999. x=211+120+45, y=294+50 -> pix_on=1 (segment c of "9").
- Second frame_start pulse 5 cycles after the first -> ignored, COMMIT still at cycle 37 after the first pulse. Assert reset at cycle 20 of a conversion -> busy=0 next cycle, display reads 000.
- in_box0 and in_box1 forced high together -> pix_on=0. Raster outside all boxes -> pix_on=0.
- LEADING_ZERO_BLANK_EN defined, cnt2=5 -> no pixels lit in cells 0 and 1 of box 2, units cell shows "5". Undefined -> cells 0 and 1 show "0".
